// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the tracking FIFO family.
// Default geometry matches the original 8-bit / 2K-word FIFO.
package fifo_pkg;

   localparam int DEFAULT_ADDR_WIDTH = 11;
   localparam int DEPTH              = 2 ** DEFAULT_ADDR_WIDTH;
   localparam int LEVEL_W            = DEFAULT_ADDR_WIDTH + 1;

   // Pointer carries one extra wrap bit beyond the RAM address.
   typedef logic [DEFAULT_ADDR_WIDTH:0] ptr_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r = r + 1;
      return r;
   endfunction

   function automatic int depth_of(input int addr_width);
      return 2 ** addr_width;
   endfunction

   function automatic int level_w_of(input int addr_width);
      return addr_width + 1;
   endfunction

endpackage

// File: rtl/tracking_fifo_sync_ram.sv
// Simple dual-port RAM, single clock, synchronous write and combinational read.
// The FIFO top registers the read data, so block RAM inference still applies.
module tracking_fifo_sync_ram #(
   parameter int WIDTH      = 8,
   parameter int ADDR_WIDTH = 11
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [WIDTH-1:0]      wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [WIDTH-1:0]      rdata
);

   logic [WIDTH-1:0] r_mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (we) r_mem[waddr] <= wdata;
   end

   assign rdata = r_mem[raddr];

endmodule

// File: rtl/tracking_fifo_sync.sv
// Single-clock FIFO that exports its live write/read addresses and occupancy
// so downstream DMA/packet logic can follow buffer position.
module tracking_fifo_sync
   import fifo_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int ADDR_WIDTH = 11,
   parameter int AF_MARGIN  = 4,
   parameter int AE_MARGIN  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [WIDTH-1:0]      data_in,
   input  logic                  write_in,
   input  logic                  read_out,
   input  logic                  flush,
   input  logic                  clear_err,
   output logic [WIDTH-1:0]      data_out,
   output logic                  valid_out,
   output logic [ADDR_WIDTH-1:0] addr_in,
   output logic [ADDR_WIDTH-1:0] addr_out,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int C_DEPTH   = depth_of(ADDR_WIDTH);
   localparam int C_LEVEL_W = level_w_of(ADDR_WIDTH);

   typedef logic [ADDR_WIDTH:0] fifo_ptr_t;

   fifo_ptr_t              r_wptr;
   fifo_ptr_t              r_rptr;
   logic [C_LEVEL_W-1:0]   r_level;
   logic [WIDTH-1:0]       r_data_out;
   logic                   r_valid;
   logic                   r_overflow;
   logic                   r_underflow;

   logic                   w_full;
   logic                   w_empty;
   logic                   w_wr_acc;
   logic                   w_rd_acc;
   logic                   w_ovf_evt;
   logic                   w_unf_evt;
   logic                   w_ram_we;
   logic [WIDTH-1:0]       w_ram_rdata;

   // Equal addresses with differing wrap bits means every slot is occupied.
   assign w_empty  = (r_wptr == r_rptr);
   assign w_full   = (r_wptr[ADDR_WIDTH-1:0] == r_rptr[ADDR_WIDTH-1:0]) &&
                     (r_wptr[ADDR_WIDTH] != r_rptr[ADDR_WIDTH]);

   assign w_wr_acc = write_in & ~w_full;
   assign w_rd_acc = read_out & ~w_empty;

   // A flush cycle ignores the handshakes, so it cannot raise an error either.
   assign w_ovf_evt = write_in & w_full  & ~flush;
   assign w_unf_evt = read_out & w_empty & ~flush;
   assign w_ram_we  = w_wr_acc & ~flush & ~reset;

   tracking_fifo_sync_ram #(
      .WIDTH      (WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk   (clk),
      .we    (w_ram_we),
      .waddr (r_wptr[ADDR_WIDTH-1:0]),
      .wdata (data_in),
      .raddr (r_rptr[ADDR_WIDTH-1:0]),
      .rdata (w_ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_level     <= '0;
         r_data_out  <= '0;
         r_valid     <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         // A new error event outranks a same-cycle clear.
         if (w_ovf_evt)      r_overflow <= 1'b1;
         else if (clear_err) r_overflow <= 1'b0;

         if (w_unf_evt)      r_underflow <= 1'b1;
         else if (clear_err) r_underflow <= 1'b0;

         if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_valid <= 1'b0;
         end else begin
            if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
            if (w_rd_acc) begin
               r_rptr     <= r_rptr + 1'b1;
               r_data_out <= w_ram_rdata;
            end
            r_valid <= w_rd_acc;
            r_level <= r_level + C_LEVEL_W'(w_wr_acc) - C_LEVEL_W'(w_rd_acc);
         end
      end
   end

   assign data_out     = r_data_out;
   assign valid_out    = r_valid;
   assign addr_in      = r_wptr[ADDR_WIDTH-1:0];
   assign addr_out     = r_rptr[ADDR_WIDTH-1:0];
   assign level        = r_level;
   assign full         = w_full;
   assign empty        = w_empty;
   assign almost_full  = (r_level >= C_LEVEL_W'(C_DEPTH - AF_MARGIN));
   assign almost_empty = (r_level <= C_LEVEL_W'(AE_MARGIN));
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

endmodule

// File: doc/tracking_fifo_sync.md
Name: tracking_fifo_sync

Overview:
- Single-clock, parametrised successor to the fixed 8-bit/2K tracking FIFO.
- Buffers WIDTH-bit words in a 2**ADDR_WIDTH-deep RAM and exports live write/read addresses plus an occupancy count, so downstream DMA/packet logic can track buffer position.
- Adds full/empty/almost flags, accept-gated handshakes, registered read with valid strobe, flush, and sticky overflow/underflow error flags.

Parameters:
- WIDTH, 8: data word width in bits.
- ADDR_WIDTH, 11: address bits; DEPTH = 2**ADDR_WIDTH words, all usable.
- AF_MARGIN, 4: almost_full asserts when level >= DEPTH - AF_MARGIN.
- AE_MARGIN, 4: almost_empty asserts when level <= AE_MARGIN.

Ports:
- clk  input  1  sole clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  write data.
- write_in  input  1  write request.
- read_out  input  1  read request.
- flush  input  1  synchronous clear of contents; error flags are kept.
- clear_err  input  1  clears overflow and underflow.
- data_out  output  WIDTH  registered read data.
- valid_out  output  1  data_out holds a newly popped word this cycle.
- addr_in  output  ADDR_WIDTH  next write address.
- addr_out  output  ADDR_WIDTH  next read address.
- level  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- full, empty, almost_full, almost_empty  output  1 each  status flags.
- overflow, underflow  output  1 each  sticky error flags.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. Reset has priority over every other input.
- Values on reset:
  - addr_in, addr_out, level, data_out, valid_out, overflow, underflow all 0.
  - empty=1, almost_empty=1, full=0, almost_full=0.
- Pointers: internal write/read pointers are ADDR_WIDTH+1 bits. addr_in and addr_out are their low ADDR_WIDTH bits and wrap modulo DEPTH.
  - empty when the pointers are equal.
  - full when the low bits are equal and the MSBs differ.
- Write acceptance:
  - wr_acc = write_in & ~full.
  - On wr_acc: mem[addr_in] <= data_in, then the write pointer increments.
  - write_in while full: the write is dropped, pointers are unchanged, and overflow is set on the next edge.
- Read acceptance:
  - rd_acc = read_out & ~empty.
  - On rd_acc: data_out <= mem[addr_out], valid_out <= 1, then the read pointer increments. Latency is 1 cycle from request to data.
  - read_out while empty: valid_out <= 0, data_out holds its value, and underflow is set.
  - data_out is never driven Z and holds its last value whenever no read is accepted.
- valid_out is a single-cycle pulse per accepted read.
- Simultaneous read and write:
  - Flags are evaluated on pre-edge state.
  - Full: only the read is accepted.
  - Empty: only the write is accepted. There is no fall-through; the word becomes readable the following cycle.
  - Otherwise both are accepted and level is unchanged.
- Level: level_next = level + wr_acc - rd_acc. It is registered and must always equal write pointer minus read pointer. All flags derive combinationally from the registered pointers and level.
- Flush: when asserted (and reset is not), both pointers and level go to 0 and valid_out goes to 0. Same-cycle write_in and read_out are ignored. overflow and underflow are retained.
- Errors:
  - clear_err clears overflow and underflow.
  - If a new error event coincides with clear_err, the set wins.
- RAM: synchronous write; read data is registered into data_out. Memory contents are not cleared by reset or flush.
- Reset mid-operation: any pending valid_out is dropped and the state is empty on the cycle after reset.

Decomposition:
- Package fifo_pkg:
  - function clog2.
  - localparam helpers DEPTH and LEVEL_W.
  - typedef for pointer width.
- Sub-module fifo_ram:
  - Simple dual-port, single clock.
  - Parameters WIDTH and ADDR_WIDTH.
  - Ports: we, waddr, wdata, raddr, rdata (asynchronous read). The top registers the output.
- Control, pointers, and flags live in the top module.

Test Plan:
All cases use WIDTH=8, ADDR_WIDTH=4 (DEPTH=16), AF_MARGIN=4, AE_MARGIN=4.
- Reset, then write 0x11, 0x22, 0x33, then read 3 cycles → data_out 0x11, 0x22, 0x33 with valid_out each cycle one cycle after the request; empty=1; level=0; addr_in=addr_out=3.
- Write 16 words 0x00..0x0F → full=1, level=16, almost_full asserted from level 12. A 17th write of 0xAA → dropped, overflow=1, level=16. Then 16 reads → 0x00..0x0F, with no 0xAA.
- Read while empty → valid_out=0, data_out unchanged, underflow=1. Then clear_err=1 for 1 cycle → underflow=0.
- At level=5, assert write_in and read_out together for 10 cycles → level stays 5 and data order is preserved. Across 20 total writes, addr_in wraps 15→0.
- Simultaneous read and write at full=1 (read only accepted) and at empty=1 (write only accepted; valid_out=0 that cycle, read succeeds next cycle).
- Flush at level=7 with overflow=1 → level=0, empty=1, addr_in=addr_out=0, overflow still 1. Reset asserted mid-burst → all outputs at reset values the next cycle.
